// File: rtl/accumulate_out_pkg.sv
// Shared types and constant helpers for the accumulator output stage.
package accumulate_out_pkg;

   localparam int ACC_LSB = 100;
   localparam int RAW_W   = 72;
   localparam int S_W     = 144;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ACC,
      ST_HI,
      ST_LO
   } out_state_t;

   // Largest signed value representable in sat_w bits, sign-extended to RAW_W.
   function automatic logic [RAW_W-1:0] sat_max(input int sat_w);
      logic [RAW_W-1:0] v;
      for (int i = 0; i < RAW_W; i++) begin
         v[i] = (i < sat_w - 1);
      end
      return v;
   endfunction

   // Smallest signed value representable in sat_w bits, sign-extended to RAW_W.
   function automatic logic [RAW_W-1:0] sat_min(input int sat_w);
      logic [RAW_W-1:0] v;
      for (int i = 0; i < RAW_W; i++) begin
         v[i] = (i >= sat_w - 1);
      end
      return v;
   endfunction

   // Half-LSB bias for round-half-up; zero when nothing is dropped.
   function automatic logic [RAW_W-1:0] rnd_bias(input int rnd_shift);
      logic [RAW_W-1:0] v;
      v = '0;
      if (rnd_shift > 0) begin
         v[rnd_shift-1] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/accumulate_round_sat.sv
// Combinational round-half-up and signed saturation of the accumulate field.
module accumulate_round_sat
   import accumulate_out_pkg::*;
#(
   parameter int ACC_W     = 44,
   parameter int RND_SHIFT = 8,
   parameter int SAT_W     = 36
) (
   input  logic [ACC_W-1:0] field,
   output logic [SAT_W-1:0] value,
   output logic             sat
);

   localparam logic [RAW_W-1:0] SAT_MAX = sat_max(SAT_W);
   localparam logic [RAW_W-1:0] SAT_MIN = sat_min(SAT_W);
   localparam logic [ACC_W:0]   BIAS    = (ACC_W+1)'(rnd_bias(RND_SHIFT));

   logic signed [ACC_W:0]   sum;
   logic signed [ACC_W:0]   t;
   logic signed [RAW_W-1:0] t_wide;

   // One extra bit keeps the rounding add from overflowing; the shifted result is then clamped.
   always_comb begin
      sum    = signed'({field[ACC_W-1], field}) + signed'(BIAS);
      t      = sum >>> RND_SHIFT;
      t_wide = {{(RAW_W-ACC_W-1){t[ACC_W]}}, t};
      value  = t_wide[SAT_W-1:0];
      sat    = 1'b0;
      if (t_wide > signed'(SAT_MAX)) begin
         value = SAT_MAX[SAT_W-1:0];
         sat   = 1'b1;
      end else if (t_wide < signed'(SAT_MIN)) begin
         value = SAT_MIN[SAT_W-1:0];
         sat   = 1'b1;
      end
   end

endmodule

// File: rtl/accumulate_out_stage.sv
// Converts the 144-bit S bus into 72-bit output beats: raw pairs or a rounded accumulate result.
module accumulate_out_stage
   import accumulate_out_pkg::*;
#(
   parameter int ACC_W     = 44,
   parameter int RND_SHIFT = 8,
   parameter int SAT_W     = 36,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [S_W-1:0]     s_in,
   input  logic               s_mode,
   input  logic               s_valid,
   output logic               s_ready,
   output logic [RAW_W-1:0]   m_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic               m_last,
   output logic               m_sat,
   output logic [CNT_W-1:0]   sat_cnt
);

   out_state_t        state;
   out_state_t        state_next;
   logic [RAW_W-1:0]  held_lo;
   logic [SAT_W-1:0]  acc_value;
   logic              acc_sat;
   logic [RAW_W-1:0]  acc_beat;
   logic              accept;

   accumulate_round_sat #(
      .ACC_W     (ACC_W),
      .RND_SHIFT (RND_SHIFT),
      .SAT_W     (SAT_W)
   ) u_round_sat (
      .field (s_in[ACC_LSB +: ACC_W]),
      .value (acc_value),
      .sat   (acc_sat)
   );

   // Handshake and beat formatting; a new word may load in the same cycle the last beat leaves.
   always_comb begin
      acc_beat = RAW_W'(signed'(acc_value));
      m_valid  = (state != ST_EMPTY);
      s_ready  = reset & ((state == ST_EMPTY) |
                          (m_ready & ((state == ST_ACC) | (state == ST_LO))));
      accept   = s_valid & s_ready;
   end

   // Next-state selection for the beat sequencer.
   always_comb begin
      state_next = state;
      case (state)
         ST_EMPTY, ST_ACC, ST_LO: begin
            if (accept) begin
               state_next = s_mode ? ST_HI : ST_ACC;
            end else if ((state != ST_EMPTY) && m_ready) begin
               state_next = ST_EMPTY;
            end
         end
         ST_HI: begin
            if (m_ready) begin
               state_next = ST_LO;
            end
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   // State register; reset drops any in-flight word immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Output beat and held low half; they stay put while downstream stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_data  <= '0;
         m_last  <= 1'b0;
         m_sat   <= 1'b0;
         held_lo <= '0;
      end else if (accept) begin
         if (s_mode) begin
            m_data  <= s_in[S_W-1:RAW_W];
            m_last  <= 1'b0;
            m_sat   <= 1'b0;
            held_lo <= s_in[RAW_W-1:0];
         end else begin
            m_data  <= acc_beat;
            m_last  <= 1'b1;
            m_sat   <= acc_sat;
         end
      end else if ((state == ST_HI) && m_ready) begin
         m_data <= held_lo;
         m_last <= 1'b1;
         m_sat  <= 1'b0;
      end
   end

   // Saturation event counter, sticky at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sat_cnt <= '0;
      end else if (m_valid && m_ready && m_sat && (sat_cnt != {CNT_W{1'b1}})) begin
         sat_cnt <= sat_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_accumulate_out_stage.sv
// Scoreboard bench for accumulate_out_stage at default parameters.
module tb_accumulate_out_stage;

   typedef struct packed {
      logic [71:0] data;
      logic        last;
      logic        sat;
   } beat_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [143:0] s_in;
   logic         s_mode;
   logic         s_valid;
   logic         s_ready;
   logic [71:0]  m_data;
   logic         m_valid;
   logic         m_ready;
   logic         m_last;
   logic         m_sat;
   logic [15:0]  sat_cnt;

   beat_t exp_q[$];
   int    n_compared    = 0;
   int    n_mismatched  = 0;
   int    cyc           = 0;
   int    beat_count    = 0;
   int    streak        = 0;
   int    last_beat_cyc = -10;
   int    exp_sat_cnt   = 0;

   accumulate_out_stage dut (
      .clk     (clk),
      .reset   (reset),
      .s_in    (s_in),
      .s_mode  (s_mode),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_last  (m_last),
      .m_sat   (m_sat),
      .sat_cnt (sat_cnt)
   );

   // 100 MHz clock and a free-running cycle index.
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
      end
   endtask

   // Reference: sign-extend, add half LSB, arithmetic shift by 8, clamp to signed 36 bits.
   function automatic beat_t model_acc(input logic [43:0] f);
      beat_t  b;
      longint v;
      longint mx;
      longint mn;
      mx = (longint'(1) <<< 35) - 1;
      mn = -(longint'(1) <<< 35);
      v  = longint'({{20{f[43]}}, f});
      v  = v + 128;
      v  = v >>> 8;
      b.sat = 1'b0;
      if (v > mx) begin
         v = mx;
         b.sat = 1'b1;
      end else if (v < mn) begin
         v = mn;
         b.sat = 1'b1;
      end
      b.data = {{8{v[63]}}, v};
      b.last = 1'b1;
      return b;
   endfunction

   function automatic logic [143:0] acc_word(input logic [43:0] f, input logic [99:0] junk);
      return {f, junk};
   endfunction

   function automatic logic [99:0] rand_junk();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[99:0];
   endfunction

   // Output monitor: every handoff is matched against the scoreboard.
   always @(negedge clk) begin
      beat_t e;
      if (reset && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", 72'(1), 72'(0));
         end else begin
            e = exp_q.pop_front();
            checkOutput("beat_data", m_data, e.data);
            checkOutput("beat_last", 72'(m_last), 72'(e.last));
            checkOutput("beat_sat", 72'(m_sat), 72'(e.sat));
            if (e.sat) exp_sat_cnt++;
         end
         beat_count++;
         streak = (last_beat_cyc + 1 == cyc) ? streak + 1 : 1;
         last_beat_cyc = cyc;
      end
   end

   // Present one word, wait (bounded) for acceptance, push expected beats, return at edge+1.
   task automatic applyStimulus(input logic mode, input logic [143:0] word);
      int    waited;
      beat_t b;
      s_in    = word;
      s_mode  = mode;
      s_valid = 1'b1;
      waited  = 0;
      @(negedge clk);
      while (!s_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!s_ready) begin
         checkOutput("accept_timeout", 72'(0), 72'(1));
         s_valid = 1'b0;
         return;
      end
      if (mode) begin
         b.data = word[143:72]; b.last = 1'b0; b.sat = 1'b0;
         exp_q.push_back(b);
         b.data = word[71:0];   b.last = 1'b1; b.sat = 1'b0;
         exp_q.push_back(b);
      end else begin
         exp_q.push_back(model_acc(word[143:100]));
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 50) begin
         @(posedge clk);
         waited++;
      end
      if (exp_q.size() != 0) checkOutput("drain_timeout", 72'(exp_q.size()), 72'(0));
      @(posedge clk);
      #1;
   endtask

   logic [43:0] rnd_fields [6] = '{44'd127, 44'd128, 44'hFFFFFFFFF80, 44'hFFFFFFFFF7F, 44'd255, 44'h3FF_FFFF_FF80};
   logic [71:0] hold_data;
   int          beats_before;

   initial begin
      reset   = 1'b0;
      s_in    = '0;
      s_mode  = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b1;

      // Reset state, s_ready forced low even with m_ready high.
      #12;
      checkOutput("rst_valid", 72'(m_valid), 72'(0));
      checkOutput("rst_data", m_data, 72'(0));
      checkOutput("rst_last", 72'(m_last), 72'(0));
      checkOutput("rst_sat", 72'(m_sat), 72'(0));
      checkOutput("rst_cnt", 72'(sat_cnt), 72'(0));
      checkOutput("rst_ready", 72'(s_ready), 72'(0));
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      checkOutput("idle_ready", 72'(s_ready), 72'(1));

      // Basic rounding: 384/256 rounds to 2; m_valid rises on the accepting edge.
      checkOutput("idle_valid", 72'(m_valid), 72'(0));
      applyStimulus(1'b0, acc_word(44'd384, 100'd0));
      checkOutput("latency_valid", 72'(m_valid), 72'(1));
      checkOutput("acc384_data", m_data, 72'd2);
      drain();

      // Positive saturation, then exact minimum (no saturation).
      applyStimulus(1'b0, acc_word(44'h7FFFFFFFFFF, rand_junk()));
      drain();
      checkOutput("satcnt_one", 72'(sat_cnt), 72'(exp_sat_cnt));
      applyStimulus(1'b0, acc_word(44'h80000000000, rand_junk()));
      checkOutput("min_data", m_data, 72'hFFFFFFFFF800000000);
      drain();

      // Rounding boundaries back-to-back, then random fields with junk low bits.
      foreach (rnd_fields[i]) applyStimulus(1'b0, acc_word(rnd_fields[i], rand_junk()));
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, acc_word(44'({$urandom, $urandom}), rand_junk()));
      drain();

      // Raw pair: high half first, s_ready low while the low half is held.
      applyStimulus(1'b1, {72'hA5A5A5A5A5A5A5A5A5, 72'h5A5A5A5A5A5A5A5A5A});
      checkOutput("raw_hi_data", m_data, 72'hA5A5A5A5A5A5A5A5A5);
      checkOutput("raw_hi_last", 72'(m_last), 72'(0));
      checkOutput("raw_hi_ready", 72'(s_ready), 72'(0));
      drain();

      // Backpressure on an ACC beat holds it; then 4 back-to-back words.
      m_ready = 1'b0;
      hold_data = model_acc(44'd1000).data;
      applyStimulus(1'b0, acc_word(44'd1000, rand_junk()));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("hold_data", m_data, hold_data);
         checkOutput("hold_ready", 72'(s_ready), 72'(0));
         @(posedge clk); #1;
      end
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, acc_word(44'(i * 777 + 5), rand_junk()));
      @(posedge clk); #1;
      // Held beat plus the four new ones leave on five consecutive edges.
      checkOutput("b2b_streak", 72'(streak), 72'(5));
      drain();
      checkOutput("satcnt_total", 72'(sat_cnt), 72'(exp_sat_cnt));

      // Reset in HI discards the held low half immediately.
      m_ready = 1'b0;
      applyStimulus(1'b1, {72'h111111111111111111, 72'h222222222222222222});
      checkOutput("hi_valid", 72'(m_valid), 72'(1));
      #2;
      reset = 1'b0;
      #1;
      checkOutput("midrst_valid", 72'(m_valid), 72'(0));
      checkOutput("midrst_cnt", 72'(sat_cnt), 72'(0));
      checkOutput("midrst_ready", 72'(s_ready), 72'(0));
      exp_q.delete();
      exp_sat_cnt = 0;
      @(posedge clk); #1;
      reset = 1'b1;
      m_ready = 1'b1;
      #1;
      checkOutput("post_rst_ready", 72'(s_ready), 72'(1));
      beats_before = beat_count;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("no_lo_beat", 72'(beat_count), 72'(beats_before));
      checkOutput("post_rst_valid", 72'(m_valid), 72'(0));
      checkOutput("queue_empty", 72'(exp_q.size()), 72'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/accumulate_out_stage.md
Name: accumulate_out_stage

Overview:
- Downstream consumer of the accumulator block's 144-bit S bus.
- Raw-pair mode: splits S into two 72-bit beats, high half first.
- Accumulate mode: takes the 44-bit result in S[143:100], rounds and saturates it to SAT_W signed bits, and emits one sign-extended 72-bit beat.
- Output uses a valid/ready stream toward the DSP output routing.

Parameters:
- ACC_W, 44, width of the accumulate field in s_in (LSB at bit 100).
- RND_SHIFT, 8, LSBs dropped with round-half-up; 0 = no rounding.
- SAT_W, 36, signed width after saturation (must be ≤ 72).
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- s_in  in  144  upstream S word.
- s_mode  in  1  1 = raw pair {hi, lo}; 0 = accumulate result.
- s_valid  in  1  s_in/s_mode valid.
- s_ready  out  1  block accepts s_in this cycle.
- m_data  out  72  output beat.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts the beat.
- m_last  out  1  final beat of the current word.
- m_sat  out  1  the current beat was saturated (accumulate mode only).
- sat_cnt  out  CNT_W  count of saturated beats handed off.

Behaviour:
- Reset (reset=0, asynchronous):
  - state EMPTY; m_valid, m_last, m_sat = 0; m_data = 0; sat_cnt = 0; held low half = 0.
  - s_ready forced to 0 while reset=0.
- States: EMPTY, ACC (one beat presented), HI (high half presented, low half held), LO (low half presented).
- s_ready = (state==EMPTY) | (m_ready & (state==ACC | state==LO)). It is combinational in m_ready, and 0 in HI.
- Accept = s_valid & s_ready. Latency is 1 cycle: m_valid rises on the clock edge that accepts.
- Accept with s_mode=1:
  - m_data ← s_in[143:72], m_last ← 0, m_sat ← 0.
  - Register s_in[71:0]; state ← HI.
- Accept with s_mode=0:
  - m_data ← sign_extend_72(round_sat(s_in[143:100])), m_last ← 1, m_sat ← saturation flag; state ← ACC.
- HI & m_ready: m_data ← held low half, m_last ← 1; state ← LO.
- ACC/LO & m_ready:
  - If a new accept occurs in the same cycle, load the new word (back-to-back, one beat per cycle).
  - Otherwise state ← EMPTY and m_valid ← 0.
- m_valid & !m_ready: m_data, m_last and m_sat hold stable; no state change.
- round_sat arithmetic:
  - Treat the 44-bit field as two's-complement signed.
  - Compute t = (field + (RND_SHIFT>0 ? 2^(RND_SHIFT-1) : 0)) in ACC_W+1 bits, then arithmetic shift right by RND_SHIFT.
  - If t > 2^(SAT_W-1)-1, output the max value; if t < -2^(SAT_W-1), output the min value. Either case sets the flag.
  - Otherwise output t unchanged, flag = 0.
- sat_cnt:
  - Increments by 1 on each handoff (m_valid & m_ready) with m_sat=1.
  - Sticks at all-ones and does not wrap.
- Reset asserted mid-word (e.g. in HI): the held low half is discarded and m_valid drops immediately.
- Bits S[99:0] are ignored in accumulate mode.

Decomposition:
- Package accumulate_out_pkg:
  - state enum (EMPTY/ACC/HI/LO);
  - ACC_LSB = 100, RAW_W = 72;
  - round/saturate constant helpers.
- Sub-module accumulate_round_sat: purely combinational rounding and saturation (field in; value and flag out), parameterised by ACC_W, RND_SHIFT and SAT_W.

Test Plan:
- Accumulate, field = 44'd384, defaults, m_ready=1 → m_data = 72'd2, m_last=1, m_sat=0, m_valid one cycle after accept.
- Field = 44'h7FFFFFFFFFF → t = 2^35, which saturates → m_data = 72'h00000000_07FFFFFFFF, m_sat=1, sat_cnt=1.
- Field = 44'h80000000000 → m_data = 72'hFFFFFFFFF800000000, m_sat=0 (exactly the minimum, no saturation).
- Raw s_in = {72'hA5A5A5A5A5A5A5A5A5, 72'h5A5A5A5A5A5A5A5A5A}, m_ready=1:
  - beat 1 = A5…, m_last=0, s_ready=0 that cycle;
  - beat 2 = 5A…, m_last=1.
- Backpressure: m_ready=0 for 3 cycles on an ACC beat → m_data stable and s_ready=0. Then 4 back-to-back accumulate words with m_ready=1 → 4 beats in 4 consecutive cycles.
- Reset=0 asserted while in HI → m_valid=0 and sat_cnt=0 at once. After release, s_ready=1 and no low beat is emitted.
